// File: rtl/oam_dma_controller_if.sv
// Signal bundle between the OAM DMA engine and the rest of the system:
// FF46 register port, shared source read bus and OAM write port.
interface oam_dma_controller_if;
  logic        reg_we;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_rdata;
  logic        dma_active;
  logic [15:0] bus_addr;
  logic        bus_re;
  logic [7:0]  bus_rdata;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        oam_we;

  // slave: the DMA engine's view; master: interconnect / CPU / memories
  modport slave (
    input  reg_we, reg_wdata, bus_rdata,
    output reg_rdata, dma_active, bus_addr, bus_re, oam_addr, oam_wdata, oam_we
  );
  modport master (
    output reg_we, reg_wdata, bus_rdata,
    input  reg_rdata, dma_active, bus_addr, bus_re, oam_addr, oam_wdata, oam_we
  );
endinterface

// File: rtl/oam_dma_controller.sv
// Game Boy OAM DMA engine: a write to FF46 copies NUM_BYTES from {src,8'h00} into OAM,
// owning the system read bus while active. All outputs are registered.
module oam_dma_controller #(
  parameter int START_DELAY     = 4,
  parameter int CYCLES_PER_BYTE = 4,
  parameter int NUM_BYTES       = 160
) (
  input  logic                 clock,
  input  logic                 reset,
  oam_dma_controller_if.slave  dma
);

  typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_XFER} state_t;

  localparam int              DLY_W     = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'((START_DELAY > 0) ? START_DELAY - 1 : 0);
  localparam int              PH_W      = $clog2(CYCLES_PER_BYTE);
  localparam logic [PH_W-1:0] PH_LAST   = PH_W'(CYCLES_PER_BYTE - 1);
  localparam logic [PH_W-1:0] PH_WRITE  = PH_W'(2);
  localparam logic [7:0]      BYTE_LAST = 8'(NUM_BYTES - 1);

  state_t           state_q, state_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [7:0]       byte_q, byte_d;
  logic [7:0]       src_q, src_d;
  logic [7:0]       regval_q, regval_d;
  logic             active_q, active_d;
  logic             bus_re_q, bus_re_d;
  logic [15:0]      bus_addr_q, bus_addr_d;
  logic             oam_we_q, oam_we_d;
  logic [7:0]       oam_addr_q, oam_addr_d;
  logic [7:0]       oam_wdata_q, oam_wdata_d;
  logic             start;

  always_comb begin
    state_d  = state_q;
    dly_d    = dly_q;
    phase_d  = phase_q;
    byte_d   = byte_q;
    src_d    = src_q;
    regval_d = regval_q;
    start    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (dma.reg_we) start = 1'b1;
      end
      ST_DELAY: begin
        if (dma.reg_we) begin
          start = 1'b1;
        end else if (dly_q == DLY_LAST) begin
          state_d = ST_XFER;
          phase_d = '0;
          byte_d  = '0;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end
      ST_XFER: begin
        if (dma.reg_we) begin
          start = 1'b1;
        end else if (phase_q == PH_LAST) begin
          if (byte_q == BYTE_LAST) begin
            state_d = ST_IDLE;
          end else begin
            byte_d  = byte_q + 8'd1;
            phase_d = '0;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A write in any state (re)starts from scratch; echo RAM E000-FDFF aliases C000-DDFF.
    if (start) begin
      regval_d = dma.reg_wdata;
      src_d    = (dma.reg_wdata >= 8'hE0) ? dma.reg_wdata - 8'h20 : dma.reg_wdata;
      dly_d    = '0;
      phase_d  = '0;
      byte_d   = '0;
      state_d  = (START_DELAY == 0) ? ST_XFER : ST_DELAY;
    end

    // Outputs are decoded from next state so they appear registered in the matching cycle.
    active_d    = (state_d != ST_IDLE);
    bus_re_d    = (state_d == ST_XFER) && (phase_d == '0);
    bus_addr_d  = bus_re_d ? {src_d, byte_d} : bus_addr_q;
    oam_we_d    = (state_d == ST_XFER) && (phase_d == PH_WRITE);
    oam_addr_d  = oam_we_d ? byte_d : oam_addr_q;
    oam_wdata_d = oam_we_d ? dma.bus_rdata : oam_wdata_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      dly_q       <= '0;
      phase_q     <= '0;
      byte_q      <= '0;
      src_q       <= '0;
      regval_q    <= 8'hFF;
      active_q    <= 1'b0;
      bus_re_q    <= 1'b0;
      bus_addr_q  <= '0;
      oam_we_q    <= 1'b0;
      oam_addr_q  <= '0;
      oam_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      dly_q       <= dly_d;
      phase_q     <= phase_d;
      byte_q      <= byte_d;
      src_q       <= src_d;
      regval_q    <= regval_d;
      active_q    <= active_d;
      bus_re_q    <= bus_re_d;
      bus_addr_q  <= bus_addr_d;
      oam_we_q    <= oam_we_d;
      oam_addr_q  <= oam_addr_d;
      oam_wdata_q <= oam_wdata_d;
    end
  end

  assign dma.reg_rdata  = regval_q;
  assign dma.dma_active = active_q;
  assign dma.bus_re     = bus_re_q;
  assign dma.bus_addr   = bus_addr_q;
  assign dma.oam_we     = oam_we_q;
  assign dma.oam_addr   = oam_addr_q;
  assign dma.oam_wdata  = oam_wdata_q;

endmodule

// File: tb/tb_oam_dma_controller.sv
// Directed testbench for oam_dma_controller: bus model, negedge monitor with event logs,
// and one task per scenario with inline expected-value checks.
module tb_oam_dma_controller;

  logic clock = 1'b0;
  logic reset = 1'b1;

  oam_dma_controller_if dif ();

  oam_dma_controller #(
    .START_DELAY(4), .CYCLES_PER_BYTE(4), .NUM_BYTES(160)
  ) dut (
    .clock(clock),
    .reset(reset),
    .dma  (dif)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Source memory model: page C1 holds i^5A, every other page holds lo^hi.
  function automatic logic [7:0] mem_data(input logic [15:0] a);
    if (a[15:8] == 8'hC1) return a[7:0] ^ 8'h5A;
    return a[7:0] ^ a[15:8];
  endfunction

  always @(posedge clock) dif.bus_rdata <= dif.bus_re ? mem_data(dif.bus_addr) : 8'h00;

  // Monitor: cumulative counters and per-event logs, sampled mid-cycle.
  int          active_cnt = 0, fall_cnt = 0, re_n = 0, we_n = 0;
  logic        prev_active = 1'b0;
  int          re_cyc [4096];
  logic [15:0] re_addr[4096];
  int          we_cyc [4096];
  logic [7:0]  we_addr[4096];
  logic [7:0]  we_data[4096];
  logic [7:0]  oam_mem[256];

  always @(negedge clock) begin
    prev_active <= (dif.dma_active === 1'b1);
    if (dif.dma_active === 1'b1) active_cnt <= active_cnt + 1;
    if (prev_active && dif.dma_active !== 1'b1) fall_cnt <= fall_cnt + 1;
    if (dif.bus_re === 1'b1) begin
      re_cyc[re_n]  <= cyc;
      re_addr[re_n] <= dif.bus_addr;
      re_n          <= re_n + 1;
    end
    if (dif.oam_we === 1'b1) begin
      we_cyc[we_n]  <= cyc;
      we_addr[we_n] <= dif.oam_addr;
      we_data[we_n] <= dif.oam_wdata;
      oam_mem[dif.oam_addr] <= dif.oam_wdata;
      we_n          <= we_n + 1;
    end
  end

  // Called at a negedge; reg_we is high for exactly the cycle numbered w.
  task automatic write_reg(input logic [7:0] v, output int w);
    dif.reg_wdata = v;
    dif.reg_we    = 1'b1;
    w             = cyc;
    @(negedge clock);
    dif.reg_we    = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    for (int k = 0; k < 2000 && dif.dma_active === 1'b1; k++) @(negedge clock);
    ok = (dif.dma_active === 1'b0);
    @(negedge clock);
  endtask

  task automatic wait_read(input logic [15:0] a, output bit ok);
    for (int k = 0; k < 2000 && !(dif.bus_re === 1'b1 && dif.bus_addr === a); k++) @(negedge clock);
    ok = (dif.bus_re === 1'b1 && dif.bus_addr === a);
  endtask

  task automatic test_reset;
    int b_re, b_we, b_act;
    dif.reg_we = 1'b0; dif.reg_wdata = 8'h00;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    n_vec++; if (dif.reg_rdata !== 8'hFF) begin n_err++; $display("FAIL reset_rdata: got %h want ff", dif.reg_rdata); end
    n_vec++; if (dif.dma_active !== 1'b0) begin n_err++; $display("FAIL reset_active: got %b want 0", dif.dma_active); end
    n_vec++; if (dif.bus_addr !== 16'h0000 || dif.oam_addr !== 8'h00 || dif.oam_wdata !== 8'h00) begin
      n_err++; $display("FAIL reset_regs: bus_addr %h oam_addr %h oam_wdata %h want 0", dif.bus_addr, dif.oam_addr, dif.oam_wdata); end
    b_re = re_n; b_we = we_n; b_act = active_cnt;
    repeat (20) @(negedge clock);
    n_vec++; if (re_n - b_re != 0 || we_n - b_we != 0 || active_cnt - b_act != 0) begin
      n_err++; $display("FAIL reset_quiet: re %0d we %0d active %0d want 0 0 0", re_n - b_re, we_n - b_we, active_cnt - b_act); end
    $display("test_reset done");
  endtask

  task automatic test_basic_copy;
    int b_re, b_we, b_act, b_fall, w, bad, first_bad;
    bit ok;
    b_re = re_n; b_we = we_n; b_act = active_cnt; b_fall = fall_cnt;
    write_reg(8'hC1, w);
    n_vec++; if (dif.dma_active !== 1'b1) begin n_err++; $display("FAIL basic_active_w1: got %b want 1", dif.dma_active); end
    n_vec++; if (dif.reg_rdata !== 8'hC1) begin n_err++; $display("FAIL basic_rdata: got %h want c1", dif.reg_rdata); end
    wait_idle(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL basic_timeout: dma_active got 1 want 0"); end
    n_vec++; if (re_cyc[b_re] != w + 5 || re_addr[b_re] !== 16'hC100) begin
      n_err++; $display("FAIL basic_first_re: cycle +%0d addr %h want +5 c100", re_cyc[b_re] - w, re_addr[b_re]); end
    n_vec++; if (re_addr[re_n-1] !== 16'hC19F) begin n_err++; $display("FAIL basic_last_re: got %h want c19f", re_addr[re_n-1]); end
    n_vec++; if (re_n - b_re != 160 || we_n - b_we != 160) begin
      n_err++; $display("FAIL basic_counts: re %0d we %0d want 160 160", re_n - b_re, we_n - b_we); end
    n_vec++; if (we_cyc[b_we] != w + 7) begin n_err++; $display("FAIL basic_first_we: cycle +%0d want +7", we_cyc[b_we] - w); end
    n_vec++; if (active_cnt - b_act != 644 || fall_cnt - b_fall != 1) begin
      n_err++; $display("FAIL basic_active_len: %0d cycles %0d falls want 644 1", active_cnt - b_act, fall_cnt - b_fall); end
    bad = 0; first_bad = -1;
    for (int i = 0; i < 160; i++) begin
      if (oam_mem[i] !== (8'(i) ^ 8'h5A)) begin bad++; if (first_bad < 0) first_bad = i; end
    end
    n_vec++; if (bad != 0) begin
      n_err++; $display("FAIL basic_oam_data: %0d bad bytes, first idx %0d got %h want %h", bad, first_bad, oam_mem[first_bad], 8'(first_bad) ^ 8'h5A); end
    $display("test_basic_copy done, W=%0d", w);
  endtask

  task automatic test_echo;
    int b_re, w;
    bit ok;
    b_re = re_n;
    write_reg(8'hE3, w);
    n_vec++; if (dif.reg_rdata !== 8'hE3) begin n_err++; $display("FAIL echo_rdata: got %h want e3", dif.reg_rdata); end
    wait_idle(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL echo_timeout: dma_active got 1 want 0"); end
    n_vec++; if (re_addr[b_re] !== 16'hC300 || re_addr[re_n-1] !== 16'hC39F) begin
      n_err++; $display("FAIL echo_addr: first %h last %h want c300 c39f", re_addr[b_re], re_addr[re_n-1]); end
    n_vec++; if (oam_mem[0] !== 8'hC3 || oam_mem[159] !== 8'h5C) begin
      n_err++; $display("FAIL echo_oam: [0]=%h [159]=%h want c3 5c", oam_mem[0], oam_mem[159]); end
    $display("test_echo done, W=%0d", w);
  endtask

  task automatic test_restart;
    int b_re, b_we, b_act, b_fall, w1, w2;
    bit ok;
    b_re = re_n; b_we = we_n; b_act = active_cnt; b_fall = fall_cnt;
    write_reg(8'hC0, w1);
    wait_read(16'hC032, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL restart_wait_byte50: bus_re %b addr %h want 1 c032", dif.bus_re, dif.bus_addr); end
    @(negedge clock);
    n_vec++; if (we_n - b_we != 50 || oam_mem[0] !== 8'hC0 || oam_mem[49] !== 8'hF1) begin
      n_err++; $display("FAIL restart_pre: we %0d [0]=%h [49]=%h want 50 c0 f1", we_n - b_we, oam_mem[0], oam_mem[49]); end
    write_reg(8'hD0, w2);
    wait_idle(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL restart_timeout: dma_active got 1 want 0"); end
    n_vec++; if (we_n - b_we != 210) begin n_err++; $display("FAIL restart_we_total: got %0d want 210", we_n - b_we); end
    n_vec++; if (we_addr[b_we+50] !== 8'h00 || we_data[b_we+50] !== 8'hD0 || we_cyc[b_we+50] != w2 + 7) begin
      n_err++; $display("FAIL restart_drop: addr %h data %h cycle +%0d want 00 d0 +7", we_addr[b_we+50], we_data[b_we+50], we_cyc[b_we+50] - w2); end
    n_vec++; if (re_addr[b_re+51] !== 16'hD000 || re_cyc[b_re+51] != w2 + 5 || re_addr[re_n-1] !== 16'hD09F) begin
      n_err++; $display("FAIL restart_reads: first %h at +%0d last %h want d000 +5 d09f", re_addr[b_re+51], re_cyc[b_re+51] - w2, re_addr[re_n-1]); end
    n_vec++; if (fall_cnt - b_fall != 1 || active_cnt - b_act != (w2 - w1) + 644) begin
      n_err++; $display("FAIL restart_active: falls %0d cycles %0d want 1 %0d", fall_cnt - b_fall, active_cnt - b_act, (w2 - w1) + 644); end
    n_vec++; if (oam_mem[50] !== 8'hE2) begin n_err++; $display("FAIL restart_oam50: got %h want e2", oam_mem[50]); end
    $display("test_restart done, W1=%0d W2=%0d", w1, w2);
  endtask

  task automatic test_reset_mid;
    int b_we, w, r_re, r_we;
    bit ok;
    b_we = we_n;
    write_reg(8'hC2, w);
    wait_read(16'hC250, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL rstmid_wait_byte80: bus_re %b addr %h want 1 c250", dif.bus_re, dif.bus_addr); end
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    n_vec++; if (dif.dma_active !== 1'b0 || dif.bus_re !== 1'b0 || dif.oam_we !== 1'b0) begin
      n_err++; $display("FAIL rstmid_strobes: active %b re %b we %b want 0 0 0", dif.dma_active, dif.bus_re, dif.oam_we); end
    n_vec++; if (dif.bus_addr !== 16'h0000 || dif.oam_addr !== 8'h00 || dif.oam_wdata !== 8'h00 || dif.reg_rdata !== 8'hFF) begin
      n_err++; $display("FAIL rstmid_regs: bus_addr %h oam_addr %h oam_wdata %h rdata %h want 0 0 0 ff",
                        dif.bus_addr, dif.oam_addr, dif.oam_wdata, dif.reg_rdata); end
    n_vec++; if (we_n - b_we != 80) begin n_err++; $display("FAIL rstmid_we_before: got %0d want 80", we_n - b_we); end
    r_re = re_n; r_we = we_n;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    n_vec++; if (re_n != r_re || we_n != r_we || dif.dma_active !== 1'b0 || dif.reg_rdata !== 8'hFF) begin
      n_err++; $display("FAIL rstmid_after: re +%0d we +%0d active %b rdata %h want 0 0 0 ff",
                        re_n - r_re, we_n - r_we, dif.dma_active, dif.reg_rdata); end
    $display("test_reset_mid done, W=%0d", w);
  endtask

  task automatic test_back_to_back;
    int b_re, b_we, b_act, b_fall, w1, w2;
    bit ok;
    b_re = re_n; b_we = we_n; b_act = active_cnt; b_fall = fall_cnt;
    write_reg(8'hC4, w1);
    for (int k = 0; k < 2000 && cyc != w1 + 644; k++) @(negedge clock);
    n_vec++; if (cyc != w1 + 644 || dif.dma_active !== 1'b1) begin
      n_err++; $display("FAIL b2b_last_cycle: cycle +%0d active %b want +644 1", cyc - w1, dif.dma_active); end
    write_reg(8'hC5, w2);
    wait_idle(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL b2b_timeout: dma_active got 1 want 0"); end
    n_vec++; if (fall_cnt - b_fall != 1 || active_cnt - b_act != 1288) begin
      n_err++; $display("FAIL b2b_active: falls %0d cycles %0d want 1 1288", fall_cnt - b_fall, active_cnt - b_act); end
    n_vec++; if (we_n - b_we != 320 || re_n - b_re != 320) begin
      n_err++; $display("FAIL b2b_counts: we %0d re %0d want 320 320", we_n - b_we, re_n - b_re); end
    n_vec++; if (re_addr[b_re+160] !== 16'hC500 || re_cyc[b_re+160] != w2 + 5 || oam_mem[159] !== 8'h5A) begin
      n_err++; $display("FAIL b2b_second: addr %h at +%0d oam[159]=%h want c500 +5 5a",
                        re_addr[b_re+160], re_cyc[b_re+160] - w2, oam_mem[159]); end
    $display("test_back_to_back done, W1=%0d W2=%0d", w1, w2);
  endtask

  initial begin
    dif.reg_we    = 1'b0;
    dif.reg_wdata = 8'h00;
    @(negedge clock);
    test_reset();
    test_basic_copy();
    test_echo();
    test_restart();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
